game_state_decoder: RTL
=======================

# game_state_decoder

Consumer of the 3-bit game `state` bus produced by the game-flow state encoder. It registers the state and produces one-hot state enables and a one-cycle entry pulse. It also generates the derived timing signals that the display and gameplay logic need: the 3-2-1 countdown digit, the "GO" flash, the pause/finish blink, and the race elapsed-seconds timer. It sits between the state encoder and the seven-segment/VGA/gameplay blocks; every downstream consumer uses its outputs instead of decoding `state` locally.

## Interface
- `SECOND`, 100000000, clock cycles per second.
- `BLINK_HALF`, 50000000, cycles per blink half-period.
- `TIME_MAX`, 5999, saturation value of `race_sec` (99:59).
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset; all registers clear immediately when low.
- `state`  in  3  encoded game state: 0 IDLE, 1 SETTING, 2 SYNCING, 3 COUNTDOWN, 4 RACING, 5 PAUSE, 6 FINISH; 7 is invalid.
- `state_onehot`  out  7  bit i high when the registered state is i.
- `state_enter`  out  1  one-cycle pulse in the first cycle of a new registered state.
- `countdown_digit`  out  2  3/2/1 during COUNTDOWN, 0 otherwise.
- `go_flash`  out  1  high for the first `SECOND` cycles of RACING entered from COUNTDOWN.
- `blink`  out  1  square wave in PAUSE and FINISH, 0 otherwise.
- `race_sec`  out  13  elapsed racing seconds.
- `race_running`  out  1  high while the registered state is RACING.

## Operation
- `state_q <= state` every cycle; invalid 7 is stored as IDLE (0). All outputs are registered.
- `state_onehot` is decoded from `state_q`; `race_running = state_onehot[4]`.
- `state_enter <= (state_eff != state_q)`, where `state_eff` is `state` with 7 mapped to 0. A 7→0 input change produces no pulse.
- Entry condition "enter X" means `state_eff == X` and `state_q != X`. Every entry-time action below lands in the same cycle that `state_onehot[X]` first rises.
- Countdown:
  - On enter COUNTDOWN: digit=3, `cd_cnt`=0.
  - While `state_q` and `state_eff` are both COUNTDOWN: `cd_cnt` increments. When it reaches `SECOND-1` it wraps to 0 and digit decrements, with a floor of 1 (holds at 1, never reaches 0 inside COUNTDOWN).
  - On leaving COUNTDOWN: digit=0.
- GO flash:
  - Enter RACING with `state_q`==COUNTDOWN: `go_flash`=1 and `go_cnt`=`SECOND-1`.
  - While in RACING: `go_cnt` decrements; `go_flash` falls in the cycle it would go below 0.
  - Any exit from RACING clears `go_flash`. Re-entry from PAUSE does not restart it.
- Blink:
  - Enter PAUSE or FINISH: `blink`=1, `bl_cnt`=0.
  - While staying in that state: at `bl_cnt`==`BLINK_HALF-1`, toggle `blink` and wrap `bl_cnt`.
  - PAUSE→FINISH direct transition counts as an entry (restart).
  - All other states: `blink`=0, `bl_cnt`=0.
- Race timer:
  - Enter COUNTDOWN, or `state_q`==IDLE: `race_sec`=0, `frac`=0.
  - While `state_q`==RACING: `frac` increments; at `SECOND-1` it wraps and `race_sec` increments, saturating at `TIME_MAX` (`frac` keeps wrapping).
  - SETTING, SYNCING, PAUSE, FINISH: `race_sec` and `frac` hold, so PAUSE→RACING resumes mid-second.

## Timing
- Reset values:
  - `state_q`=IDLE, `state_onehot`=7'b0000001.
  - `state_enter`=0, `countdown_digit`=0, `go_flash`=0, `blink`=0, `race_sec`=0, `race_running`=0.
  - All internal counters 0.
- Latency:
  - `state` to `state_onehot`, `state_enter`, and all entry actions: 1 cycle.
  - Countdown digit periods are exactly `SECOND` cycles each; 3 occupies cycles 0..SECOND-1 after entry.
  - First `race_sec` increment occurs `SECOND` cycles after the first RACING cycle of `state_q`.
- Simultaneous events: entry actions take priority over in-state counting. Back-to-back state changes on consecutive cycles each produce a `state_enter` pulse.
- Reset asserted mid-operation clears everything asynchronously. After release, the first cycle behaves as if coming from IDLE.

## Test plan
Bench parameters for all scenarios: `SECOND`=10, `BLINK_HALF`=4, `TIME_MAX`=5.
- Reset release with `state`=0 -> `state_onehot`=0000001, all other outputs 0, `state_enter` never pulses.
- `state` 0→3, held 35 cycles -> single `state_enter` pulse; `countdown_digit` 3 for 10 cycles, 2 for 10, then 1 held; back to 0 one cycle after `state` leaves 3.
- `state` 3→4, held 25 cycles -> `go_flash` high exactly 10 cycles; `race_sec` reaches 1 after 10 cycles and 2 after 20 cycles.
- RACING 15 cycles, PAUSE 9 cycles, RACING 5 cycles -> `race_sec`=1 held through PAUSE, becomes 2 on the 5th RACING cycle; `blink` sequence in PAUSE is 1×4, 0×4, 1×1; `go_flash` does not restart.
- RACING held 80 cycles -> `race_sec` saturates at 5; then `state`=6 -> value held and `blink` toggles; then `state`=0 -> `race_sec`=0.
- `state`=7 -> `state_onehot`=0000001 and no `state_enter` pulse from IDLE; `rst` pulsed low mid-countdown -> all outputs 0 immediately, `state_onehot` returns to 0000001.

Source files
------------

// File: rtl/game_state_decoder_if.sv
// -----------------------------------------------------------------------------
// game_state_decoder_if
// Bundle between the game-flow state encoder (master) and the state decoder
// (slave), plus the decoded outputs consumed by display/gameplay logic.
//   state            encoded game state (master -> slave)
//   state_onehot     one-hot registered state
//   state_enter      one-cycle pulse on entry to a new state
//   countdown_digit  3/2/1 during COUNTDOWN, 0 otherwise
//   go_flash         "GO" indicator after COUNTDOWN -> RACING
//   blink            square wave in PAUSE / FINISH
//   race_sec         elapsed racing seconds (saturating)
//   race_running     registered state is RACING
// -----------------------------------------------------------------------------
interface game_state_decoder_if;
   logic [2:0]  state;
   logic [6:0]  state_onehot;
   logic        state_enter;
   logic [1:0]  countdown_digit;
   logic        go_flash;
   logic        blink;
   logic [12:0] race_sec;
   logic        race_running;

   modport master (
      output state,
      input  state_onehot, state_enter, countdown_digit, go_flash,
             blink, race_sec, race_running
   );

   modport slave (
      input  state,
      output state_onehot, state_enter, countdown_digit, go_flash,
             blink, race_sec, race_running
   );
endinterface

// File: rtl/game_state_decoder.sv
// -----------------------------------------------------------------------------
// game_state_decoder
// Registers the encoded game state and derives every timing signal the
// display and gameplay blocks need (countdown digit, GO flash, pause/finish
// blink, race seconds timer). All outputs are registered.
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   game_state_decoder_if.slave (state in, decoded outputs out)
// -----------------------------------------------------------------------------
module game_state_decoder #(
   parameter int SECOND     = 100000000,
   parameter int BLINK_HALF = 50000000,
   parameter int TIME_MAX   = 5999
) (
   input  logic                  clk,
   input  logic                  rst,
   game_state_decoder_if.slave   bus
);

   localparam int CW = (SECOND > 1) ? $clog2(SECOND) : 1;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [CW-1:0] SEC_LAST = CW'(SECOND - 1);
   localparam logic [BW-1:0] BL_LAST  = BW'(BLINK_HALF - 1);
   localparam logic [12:0]   SEC_MAX  = 13'(TIME_MAX);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SETTING   = 3'd1,
      ST_SYNCING   = 3'd2,
      ST_COUNTDOWN = 3'd3,
      ST_RACING    = 3'd4,
      ST_PAUSE     = 3'd5,
      ST_FINISH    = 3'd6
   } game_state_t;

   game_state_t    state_r;
   game_state_t    state_eff_s;
   logic           enter_cd_s;
   logic           stay_cd_s;
   logic           go_start_s;
   logic           stay_race_s;
   logic           enter_pf_s;
   logic           stay_pf_s;

   logic [6:0]     state_onehot_r;
   logic           state_enter_r;
   logic           race_running_r;
   logic [1:0]     digit_r;
   logic [CW-1:0]  cd_cnt_r;
   logic           go_flash_r;
   logic [CW-1:0]  go_cnt_r;
   logic           blink_r;
   logic [BW-1:0]  bl_cnt_r;
   logic [12:0]    race_sec_r;
   logic [CW-1:0]  frac_r;

   function automatic logic [6:0] onehot7(input game_state_t s);
      case (s)
         ST_IDLE:      onehot7 = 7'b0000001;
         ST_SETTING:   onehot7 = 7'b0000010;
         ST_SYNCING:   onehot7 = 7'b0000100;
         ST_COUNTDOWN: onehot7 = 7'b0001000;
         ST_RACING:    onehot7 = 7'b0010000;
         ST_PAUSE:     onehot7 = 7'b0100000;
         ST_FINISH:    onehot7 = 7'b1000000;
         default:      onehot7 = 7'b0000001;
      endcase
   endfunction

   // Sanitise the input state (7 folds onto IDLE) and derive entry/stay flags.
   always_comb begin
      state_eff_s = ST_IDLE;
      if (bus.state == 3'd7) begin
         state_eff_s = ST_IDLE;
      end else begin
         state_eff_s = game_state_t'(bus.state);
      end
      enter_cd_s  = (state_eff_s == ST_COUNTDOWN) && (state_r != ST_COUNTDOWN);
      stay_cd_s   = (state_eff_s == ST_COUNTDOWN) && (state_r == ST_COUNTDOWN);
      go_start_s  = (state_eff_s == ST_RACING)    && (state_r == ST_COUNTDOWN);
      stay_race_s = (state_eff_s == ST_RACING)    && (state_r == ST_RACING);
      // PAUSE -> FINISH counts as a fresh entry, so compare against the exact state.
      enter_pf_s  = ((state_eff_s == ST_PAUSE)  && (state_r != ST_PAUSE)) ||
                    ((state_eff_s == ST_FINISH) && (state_r != ST_FINISH));
      stay_pf_s   = (state_eff_s == state_r) &&
                    ((state_r == ST_PAUSE) || (state_r == ST_FINISH));
   end

   // State register, decoded enables and all derived timers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r        <= ST_IDLE;
         state_onehot_r <= 7'b0000001;
         state_enter_r  <= 1'b0;
         race_running_r <= 1'b0;
         digit_r        <= 2'd0;
         cd_cnt_r       <= {CW{1'b0}};
         go_flash_r     <= 1'b0;
         go_cnt_r       <= {CW{1'b0}};
         blink_r        <= 1'b0;
         bl_cnt_r       <= {BW{1'b0}};
         race_sec_r     <= 13'd0;
         frac_r         <= {CW{1'b0}};
      end else begin
         state_r        <= state_eff_s;
         state_onehot_r <= onehot7(state_eff_s);
         state_enter_r  <= (state_eff_s != state_r);
         race_running_r <= (state_eff_s == ST_RACING);

         // Countdown digit: 3 on entry, one step down per second, floor of 1.
         if (enter_cd_s) begin
            digit_r  <= 2'd3;
            cd_cnt_r <= {CW{1'b0}};
         end else if (stay_cd_s) begin
            if (cd_cnt_r == SEC_LAST) begin
               cd_cnt_r <= {CW{1'b0}};
               if (digit_r > 2'd1) begin
                  digit_r <= digit_r - 2'd1;
               end else begin
                  digit_r <= 2'd1;
               end
            end else begin
               cd_cnt_r <= cd_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
         end else begin
            digit_r  <= 2'd0;
            cd_cnt_r <= {CW{1'b0}};
         end

         // GO flash: only a COUNTDOWN -> RACING entry arms it; resuming
         // from PAUSE lands in the final branch and keeps it low.
         if (go_start_s) begin
            go_flash_r <= 1'b1;
            go_cnt_r   <= SEC_LAST;
         end else if (stay_race_s) begin
            if (go_cnt_r == {CW{1'b0}}) begin
               go_flash_r <= 1'b0;
            end else begin
               go_cnt_r <= go_cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
         end else begin
            go_flash_r <= 1'b0;
            go_cnt_r   <= {CW{1'b0}};
         end

         // Blink: starts high on entry, toggles every half period.
         if (enter_pf_s) begin
            blink_r  <= 1'b1;
            bl_cnt_r <= {BW{1'b0}};
         end else if (stay_pf_s) begin
            if (bl_cnt_r == BL_LAST) begin
               blink_r  <= ~blink_r;
               bl_cnt_r <= {BW{1'b0}};
            end else begin
               bl_cnt_r <= bl_cnt_r + {{(BW-1){1'b0}}, 1'b1};
            end
         end else begin
            blink_r  <= 1'b0;
            bl_cnt_r <= {BW{1'b0}};
         end

         // Race timer: runs only while RACING, holds elsewhere so a pause
         // resumes mid-second.
         if (enter_cd_s || (state_r == ST_IDLE)) begin
            race_sec_r <= 13'd0;
            frac_r     <= {CW{1'b0}};
         end else if (state_r == ST_RACING) begin
            if (frac_r == SEC_LAST) begin
               frac_r <= {CW{1'b0}};
               if (race_sec_r != SEC_MAX) begin
                  race_sec_r <= race_sec_r + 13'd1;
               end else begin
                  race_sec_r <= race_sec_r;
               end
            end else begin
               frac_r <= frac_r + {{(CW-1){1'b0}}, 1'b1};
            end
         end else begin
            race_sec_r <= race_sec_r;
            frac_r     <= frac_r;
         end
      end
   end

   assign bus.state_onehot    = state_onehot_r;
   assign bus.state_enter     = state_enter_r;
   assign bus.countdown_digit = digit_r;
   assign bus.go_flash        = go_flash_r;
   assign bus.blink           = blink_r;
   assign bus.race_sec        = race_sec_r;
   assign bus.race_running    = race_running_r;

endmodule
